// File: rtl/gain_offset_calibrator.sv
// Block calibrator: accumulates 2^LOG2_N signed samples, then derives a gain
// (TARGET_PEAK / half-span via restoring division) and an offset that cancels the mean.
module gain_offset_calibrator #(
    parameter int unsigned IN_WIDTH     = 8,
    parameter int unsigned GAIN_WIDTH   = 16,
    parameter int unsigned GAIN_RADIX   = 8,
    parameter int unsigned OFFSET_WIDTH = 8,
    parameter int unsigned LOG2_N       = 10,
    parameter int unsigned TARGET_PEAK  = 100
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic                           in_valid,
    input  logic signed [IN_WIDTH-1:0]     in,
    output logic                           busy,
    output logic                           done,
    output logic                           cal_valid,
    output logic        [GAIN_WIDTH-1:0]   gain,
    output logic signed [OFFSET_WIDTH-1:0] offset
);

    localparam int unsigned SUM_W  = IN_WIDTH + LOG2_N;
    localparam int unsigned HS_W   = IN_WIDTH + 1;
    localparam int unsigned REM_W  = HS_W + 1;
    localparam int unsigned DW     = IN_WIDTH + GAIN_RADIX;
    localparam int unsigned CNT_W  = $clog2(DW + 1);
    localparam int unsigned QEXT_W = DW + GAIN_WIDTH;
    localparam int unsigned PROD_W = IN_WIDTH + GAIN_WIDTH + 1;

    localparam logic [DW-1:0]              DIVIDEND = DW'(TARGET_PEAK << GAIN_RADIX);
    localparam logic [QEXT_W-1:0]          GAIN_MAX = QEXT_W'({GAIN_WIDTH{1'b1}});
    localparam logic signed [PROD_W:0]     OFF_MAX  = (PROD_W + 1)'(2 ** (OFFSET_WIDTH - 1) - 1);
    localparam logic signed [PROD_W:0]     OFF_MIN  = -OFF_MAX - (PROD_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        MEAN   = 3'd2,
        DIVIDE = 3'd3,
        OFFSET = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic signed [SUM_W-1:0]    sum_q;
    logic        [LOG2_N-1:0]   count_q;
    logic signed [IN_WIDTH-1:0] max_q, min_q, mean_q;
    logic        [HS_W-1:0]     half_span_q;
    logic        [HS_W-1:0]     rem_q;
    logic        [DW-1:0]       dvd_q, quot_q;
    logic        [CNT_W-1:0]    div_cnt_q;
    logic        [GAIN_WIDTH-1:0] gain_q;

    logic                       sample_c, last_sample_c, div_last_c, ge_c;
    logic        [HS_W-1:0]     diff_c, half_span_c;
    logic        [REM_W-1:0]    trial_c, rem_next_c;
    logic        [DW-1:0]       quot_next_c;
    logic signed [IN_WIDTH-1:0] mean_c;
    logic signed [PROD_W-1:0]   prod_c, scaled_c;
    logic signed [PROD_W:0]     neg_c;
    logic signed [OFFSET_WIDTH-1:0] off_sat_c;

    // Datapath combinational terms
    always_comb begin
        sample_c      = (state_q == ACCUM) && in_valid;
        last_sample_c = sample_c && (count_q == '1);
        diff_c        = {max_q[IN_WIDTH-1], max_q} - {min_q[IN_WIDTH-1], min_q};
        half_span_c   = diff_c >> 1;
        mean_c        = IN_WIDTH'(sum_q >>> LOG2_N);
        trial_c       = {rem_q, dvd_q[DW-1]};
        ge_c          = trial_c >= {1'b0, half_span_q};
        rem_next_c    = ge_c ? (trial_c - {1'b0, half_span_q}) : trial_c;
        quot_next_c   = {quot_q[DW-2:0], ge_c};
        div_last_c    = (div_cnt_q == CNT_W'(DW - 1));
        prod_c        = PROD_W'(mean_q) * PROD_W'($signed({1'b0, gain_q}));
        scaled_c      = prod_c >>> GAIN_RADIX;
        neg_c         = -((PROD_W + 1)'(scaled_c));
        if (neg_c > OFF_MAX)
            off_sat_c = OFFSET_WIDTH'(OFF_MAX);
        else if (neg_c < OFF_MIN)
            off_sat_c = OFFSET_WIDTH'(OFF_MIN);
        else
            off_sat_c = OFFSET_WIDTH'(neg_c);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (last_sample_c) state_d = MEAN;
            MEAN:    state_d = (half_span_c == '0) ? OFFSET : DIVIDE;
            DIVIDE:  if (div_last_c) state_d = OFFSET;
            OFFSET:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Accumulation, statistics and divider registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_q       <= '0;
            count_q     <= '0;
            max_q       <= '0;
            min_q       <= '0;
            mean_q      <= '0;
            half_span_q <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            quot_q      <= '0;
            div_cnt_q   <= '0;
            gain_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    sum_q   <= '0;
                    count_q <= '0;
                    max_q   <= {1'b1, {(IN_WIDTH - 1){1'b0}}};
                    min_q   <= {1'b0, {(IN_WIDTH - 1){1'b1}}};
                end
                ACCUM: if (sample_c) begin
                    sum_q   <= sum_q + SUM_W'(in);
                    count_q <= count_q + LOG2_N'(1);
                    if (in > max_q) max_q <= in;
                    if (in < min_q) min_q <= in;
                end
                MEAN: begin
                    mean_q      <= mean_c;
                    half_span_q <= half_span_c;
                    rem_q       <= '0;
                    dvd_q       <= DIVIDEND;
                    quot_q      <= '0;
                    div_cnt_q   <= '0;
                    if (half_span_c == '0) gain_q <= '1;
                end
                DIVIDE: begin
                    rem_q     <= HS_W'(rem_next_c);
                    dvd_q     <= {dvd_q[DW-2:0], 1'b0};
                    quot_q    <= quot_next_c;
                    div_cnt_q <= div_cnt_q + CNT_W'(1);
                    // Quotient may exceed the gain range when DW > GAIN_WIDTH
                    if (div_last_c)
                        gain_q <= (QEXT_W'(quot_next_c) > GAIN_MAX) ? '1 : GAIN_WIDTH'(quot_next_c);
                end
                default: ;
            endcase
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cal_valid <= 1'b0;
            gain      <= '0;
            offset    <= '0;
        end else begin
            busy <= (state_d != IDLE);
            done <= (state_d == DONE);
            if ((state_q == IDLE) && start)
                cal_valid <= 1'b0;
            else if (state_q == OFFSET)
                cal_valid <= 1'b1;
            if (state_q == OFFSET) begin
                gain   <= gain_q;
                offset <= off_sat_c;
            end
        end
    end

endmodule

// File: tb/tb_gain_offset_calibrator.sv
// Directed bench for gain_offset_calibrator with LOG2_N=4 (16-sample blocks).
module tb_gain_offset_calibrator;

    localparam int unsigned IW  = 8;
    localparam int unsigned GW  = 16;
    localparam int unsigned OW  = 8;
    localparam int unsigned L2N = 4;
    localparam int unsigned NS  = 2 ** L2N;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 start = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [IW-1:0] in_s = '0;
    logic                 busy, done, cal_valid;
    logic [GW-1:0]        gain;
    logic signed [OW-1:0] offset;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gain_offset_calibrator #(
        .IN_WIDTH(8), .GAIN_WIDTH(16), .GAIN_RADIX(8), .OFFSET_WIDTH(8),
        .LOG2_N(L2N), .TARGET_PEAK(100)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in(in_s),
        .busy(busy), .done(done), .cal_valid(cal_valid), .gain(gain), .offset(offset)
    );

    // Runs one calibration; returns edges from final sample to done (-1 on timeout)
    task automatic calibrate(input logic signed [IW-1:0] a, input logic signed [IW-1:0] b,
                             input bit gaps, input bit extra_start, output int lat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || cal_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_ack: busy=%b cal_valid=%b, required busy=1 cal_valid=0", busy, cal_valid);
        end
        for (int i = 0; i < NS; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_s     = 8'sd127;
                if (extra_start && i == 6) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_s     = (i % 2 == 0) ? a : b;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_s     = '0;
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) lat = k;
        end
    endtask

    // Result checks shared by the calibration scenarios
    task automatic check_result(input string name, input int lat, input int exp_lat,
                                input logic [GW-1:0] exp_gain, input logic signed [OW-1:0] exp_off);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges, required %0d", name, lat, exp_lat);
        end
        checks++;
        if (gain !== exp_gain) begin
            errors++;
            $display("FAIL %s_gain: got 0x%h, required 0x%h", name, gain, exp_gain);
        end
        checks++;
        if (offset !== exp_off) begin
            errors++;
            $display("FAIL %s_offset: got %0d, required %0d", name, offset, exp_off);
        end
        checks++;
        if (cal_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_flags: cal_valid=%b busy=%b, required 1 1", name, cal_valid, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || gain !== exp_gain) begin
            errors++;
            $display("FAIL %s_after_done: done=%b busy=%b gain=0x%h, required 0 0 0x%h",
                     name, done, busy, gain, exp_gain);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cal_valid !== 1'b0 || gain !== '0 || offset !== '0) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b cal_valid=%b gain=0x%h offset=%0d, required all 0",
                     busy, done, cal_valid, gain, offset);
        end
        #21 rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || cal_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b cal_valid=%b, required 0 0", busy, cal_valid);
        end
    endtask

    task automatic test_zero_span_const();
        int lat;
        calibrate(8'sd5, 8'sd5, 1'b0, 1'b0, lat);
        check_result("const5", lat, 2, 16'hFFFF, -8'sd128);
    endtask

    task automatic test_symmetric();
        int lat;
        calibrate(8'sd50, -8'sd50, 1'b0, 1'b0, lat);
        check_result("pm50", lat, 18, 16'h0200, 8'sd0);
    endtask

    task automatic test_offset_mean();
        int lat;
        calibrate(8'sd21, -8'sd19, 1'b0, 1'b0, lat);
        check_result("p21m19", lat, 18, 16'd1280, -8'sd5);
    endtask

    task automatic test_negative_floor();
        int lat;
        calibrate(-8'sd1, -8'sd2, 1'b0, 1'b0, lat);
        check_result("m1m2", lat, 2, 16'hFFFF, 8'sd127);
    endtask

    task automatic test_gaps_and_restart();
        int lat;
        calibrate(8'sd21, -8'sd19, 1'b1, 1'b1, lat);
        check_result("gaps", lat, 18, 16'd1280, -8'sd5);
    endtask

    task automatic test_reset_abort();
        int lat;
        bit saw_done;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_s     = 8'sd30;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #3 rstn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || cal_valid !== 1'b0 || gain !== '0 || offset !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: busy=%b cal_valid=%b gain=0x%h offset=%0d done=%b, required all 0",
                     busy, cal_valid, gain, offset, done);
        end
        #10 rstn = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: done/busy asserted after abort, required both held at 0");
        end
        calibrate(8'sd50, -8'sd50, 1'b0, 1'b0, lat);
        check_result("after_abort", lat, 18, 16'h0200, 8'sd0);
    endtask

    initial begin
        test_reset();
        test_zero_span_const();
        test_symmetric();
        test_offset_mean();
        test_negative_floor();
        test_gaps_and_restart();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
